// File: rtl/mau_n_fx.sv
// Parametrised fixed-point matrix-vector unit: y = M*v with round-half-up and saturation.
// Optional MAU_TRANSPOSE_EN adds a transpose input so that y = M^T*v can be selected per operation.
module mau_n_fx #(
  parameter int DIM    = 4,
  parameter int LANES  = 2,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES*DATA_W-1:0]   data_in,
  input  logic                      set_matrix_address,
  input  logic                      write_matrix,
  input  logic                      start,
  input  logic                      vec_valid,
  input  logic                      read_output,
`ifdef MAU_TRANSPOSE_EN
  input  logic                      transpose,
`endif
  output logic [LANES*DATA_W-1:0]   data_out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      result_ready,
  output logic [1:0]                state_dbg
);

  localparam int BEATS  = DIM * DIM / LANES;
  localparam int VBEATS = DIM / LANES;
  localparam int BA_W   = $clog2(BEATS);
  localparam int CB_W   = (VBEATS > 1) ? $clog2(VBEATS) : 1;
  localparam int RW     = $clog2(DIM);
  localparam int MI_W   = $clog2(DIM * DIM);
  localparam int PW     = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(DIM);
  localparam logic signed [ACC_W:0] RND  = (ACC_W + 1)'(1) << (FRAC_W - 1);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  // Handshake: single-cycle strobes, all sampled at the rising edge. A read strobe is
  // honoured only while result_ready is high, and answered on the following cycle with
  // out_valid high for exactly one cycle; vec_valid may stall indefinitely.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_VEC = 2'd1, COMPUTE = 2'd2} state_t;
  state_t state;

  logic signed [DATA_W-1:0] mat [DIM*DIM];
  logic signed [DATA_W-1:0] vec [DIM];
  logic signed [DATA_W-1:0] y   [DIM];
  logic [BA_W-1:0]          ba;
  logic [CB_W-1:0]          vbeat, cb, rp;
  logic [RW-1:0]            row;
  logic signed [ACC_W-1:0]  acc, psum, acc_next;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W:0]    rounded, shifted;
  logic signed [DATA_W-1:0] y_sat;
  int                       col, idx;

`ifdef MAU_TRANSPOSE_EN
  logic tp_q;
`else
  localparam logic tp_q = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // One beat of partial products for the current row, plus rounding of the finished row.
  always_comb begin
    psum = '0;
    prod = '0;
    col  = 0;
    idx  = 0;
    for (int k = 0; k < LANES; k++) begin
      col  = int'(cb) * LANES + k;
      idx  = tp_q ? col * DIM + int'(row) : int'(row) * DIM + col;
      prod = PW'(mat[MI_W'(idx)]) * PW'(vec[RW'(col)]);
      psum = psum + ACC_W'(prod);
    end
    acc_next = acc + psum;
    rounded  = {acc_next[ACC_W-1], acc_next} + RND;
    shifted  = rounded >>> FRAC_W;
    if (shifted > MAXV)      y_sat = DATA_W'(MAXV);
    else if (shifted < MINV) y_sat = DATA_W'(MINV);
    else                     y_sat = DATA_W'(shifted);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      ba           <= '0;
      vbeat        <= '0;
      cb           <= '0;
      rp           <= '0;
      row          <= '0;
      acc          <= '0;
      data_out     <= '0;
      out_valid    <= 1'b0;
      result_ready <= 1'b0;
`ifdef MAU_TRANSPOSE_EN
      tp_q         <= 1'b0;
`endif
      for (int i = 0; i < DIM * DIM; i++) mat[i] <= '0;
      for (int i = 0; i < DIM; i++) begin
        vec[i] <= '0;
        y[i]   <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (read_output && result_ready) begin
        for (int k = 0; k < LANES; k++)
          data_out[k*DATA_W +: DATA_W] <= y[RW'(int'(rp) * LANES + k)];
        out_valid <= 1'b1;
        if (rp == CB_W'(VBEATS - 1)) begin
          result_ready <= 1'b0;
          rp           <= '0;
        end else begin
          rp <= rp + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (set_matrix_address) begin
            ba <= data_in[BA_W-1:0];
          end else if (write_matrix) begin
            for (int k = 0; k < LANES; k++)
              mat[MI_W'(int'(ba) * LANES + k)] <= data_in[k*DATA_W +: DATA_W];
            ba <= ba + 1'b1;
          end
          if (start) begin
            for (int k = 0; k < LANES; k++)
              vec[k] <= data_in[k*DATA_W +: DATA_W];
            result_ready <= 1'b0;
            rp           <= '0;
            vbeat        <= CB_W'(1);
            cb           <= '0;
            row          <= '0;
            acc          <= '0;
`ifdef MAU_TRANSPOSE_EN
            tp_q         <= transpose;
`endif
            state        <= (VBEATS == 1) ? COMPUTE : LOAD_VEC;
          end
        end
        LOAD_VEC: begin
          if (vec_valid) begin
            for (int k = 0; k < LANES; k++)
              vec[RW'(int'(vbeat) * LANES + k)] <= data_in[k*DATA_W +: DATA_W];
            vbeat <= vbeat + 1'b1;
            if (vbeat == CB_W'(VBEATS - 1)) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (cb == CB_W'(VBEATS - 1)) begin
            y[row] <= y_sat;
            acc    <= '0;
            cb     <= '0;
            if (row == RW'(DIM - 1)) begin
              row          <= '0;
              result_ready <= 1'b1;
              state        <= IDLE;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            acc <= acc_next;
            cb  <= cb + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mau_n_fx.sv
// Scoreboard bench for mau_n_fx (DIM=4, LANES=2, Q8.8): reference model of matrix storage,
// beat addressing and fixed-point M*v; a monitor checks every out_valid beat against exp_q.
module tb_mau_n_fx;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in = '0;
  logic        set_matrix_address = 1'b0;
  logic        write_matrix = 1'b0;
  logic        start = 1'b0;
  logic        vec_valid = 1'b0;
  logic        read_output = 1'b0;
`ifdef MAU_TRANSPOSE_EN
  logic        transpose = 1'b0;
`endif
  logic [31:0] data_out;
  logic        out_valid, busy, result_ready;
  logic [1:0]  state_dbg;

  mau_n_fx dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .set_matrix_address(set_matrix_address), .write_matrix(write_matrix),
    .start(start), .vec_valid(vec_valid), .read_output(read_output),
`ifdef MAU_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .data_out(data_out), .out_valid(out_valid), .busy(busy),
    .result_ready(result_ready), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [31:0]        exp_q[$];
  logic [31:0]        mon_exp;
  int                 total = 0;
  int                 bad = 0;
  logic signed [15:0] m_ref [16];
  logic signed [15:0] v_ref [4];
  logic [15:0]        mat_in [16];
  logic [15:0]        y_exp [4];
  int                 ba_ref = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h with out_valid=1, expected no beat", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("read_beat", data_out, mon_exp);
      end
    end
  end

  function automatic logic [15:0] ref_y(input int r, input bit tp);
    longint acc;
    acc = 0;
    for (int c = 0; c < 4; c++)
      acc += longint'(tp ? m_ref[c*4 + r] : m_ref[r*4 + c]) * longint'(v_ref[c]);
    acc = (acc + 128) >>> 8;
    if (acc > 32767)  return 16'h7fff;
    if (acc < -32768) return 16'h8000;
    return 16'(acc);
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 2048)) - 16'd1024;
      1:       return ($urandom_range(0, 1) == 1) ? 16'h7f00 : 16'h8000;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic set_addr(input int a);
    data_in = ($urandom() & 32'hffff_fff8) | 32'(a & 7);
    set_matrix_address = 1'b1;
    tick();
    set_matrix_address = 1'b0;
    ba_ref = a & 7;
  endtask

  task automatic write_beat(input logic [15:0] w0, input logic [15:0] w1);
    data_in = {w1, w0};
    write_matrix = 1'b1;
    tick();
    write_matrix = 1'b0;
    m_ref[ba_ref*2]     = w0;
    m_ref[ba_ref*2 + 1] = w1;
    ba_ref = (ba_ref + 1) % 8;
  endtask

  task automatic load_matrix();
    set_addr(0);
    for (int b = 0; b < 8; b++) write_beat(mat_in[2*b], mat_in[2*b + 1]);
  endtask

  task automatic read_all();
    for (int b = 0; b < 2; b++) begin
      exp_q.push_back({y_exp[2*b + 1], y_exp[2*b]});
      read_output = 1'b1;
      tick();
      read_output = 1'b0;
    end
    check("rr_cleared", 32'(result_ready), 32'd0);
    read_output = 1'b1;
    tick();
    read_output = 1'b0;
    check("data_hold", data_out, {y_exp[3], y_exp[2]});
  endtask

  // Full operation: start, optional stalled second beat, latency check, readout.
  task automatic run_op(input int stall, input bit tp, input bit poke_start, input bit poke_write);
    int n;
`ifdef MAU_TRANSPOSE_EN
    transpose = tp;
`endif
    data_in = {v_ref[1], v_ref[0]};
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_load", 32'(busy), 32'd1);
    for (int s = 0; s < stall; s++) begin
      if (poke_write) begin
        write_matrix = 1'b1;
        data_in = $urandom();
      end
      tick();
    end
    write_matrix = 1'b0;
    data_in = {v_ref[3], v_ref[2]};
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    n = 0;
    while (!result_ready && n < 40) begin
      start = (poke_start && n == 2);
      data_in = $urandom();
      tick();
      n++;
    end
    start = 1'b0;
    check("latency", 32'(n), 32'd8);
    check("busy_done", 32'(busy), 32'd0);
    for (int r = 0; r < 4; r++) y_exp[r] = ref_y(r, tp);
    read_all();
  endtask

  task automatic clear_mat_in();
    for (int i = 0; i < 16; i++) mat_in[i] = 16'h0000;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_ref[i] = '0;
    for (int i = 0; i < 4; i++) v_ref[i] = '0;
    repeat (2) tick();
    check("rst_data_out", data_out, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result_ready", 32'(result_ready), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    tick();

    // Identity
    clear_mat_in();
    for (int i = 0; i < 4; i++) mat_in[i*5] = 16'h0100;
    load_matrix();
    v_ref = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    run_op(0, 1'b0, 1'b0, 1'b0);
    check("identity_y0", 32'(y_exp[0]), 32'h0100);

    // Saturation both directions
    clear_mat_in();
    for (int c = 0; c < 4; c++) begin
      mat_in[c]     = 16'h7f00;
      mat_in[4 + c] = 16'h8000;
    end
    load_matrix();
    v_ref = '{16'h7f00, 16'h7f00, 16'h7f00, 16'h7f00};
    run_op(0, 1'b0, 1'b0, 1'b0);

    // Rounding of a negative product, then round-half-up of +0.5 lsb
    clear_mat_in();
    mat_in[0] = 16'hff00;
    load_matrix();
    v_ref = '{16'h0080, 16'h0000, 16'h0000, 16'h0000};
    run_op(0, 1'b0, 1'b0, 1'b0);
    mat_in[0] = 16'h0001;
    load_matrix();
    run_op(1, 1'b0, 1'b0, 1'b0);

    // Addressing: wrap from beat 7 to 0, and set/write collision writes nothing
    clear_mat_in();
    load_matrix();
    set_addr(7);
    write_beat(16'h0a00, 16'h0b00);
    write_beat(16'h0c00, 16'h0d00);
    data_in = {16'h5555, 16'h5553};
    set_matrix_address = 1'b1;
    write_matrix = 1'b1;
    tick();
    set_matrix_address = 1'b0;
    write_matrix = 1'b0;
    ba_ref = 3;
    write_beat(16'h0e00, 16'h0f00);
    v_ref = '{16'h0100, 16'h0080, 16'hff00, 16'h0200};
    run_op(0, 1'b0, 1'b0, 1'b0);

    // Protocol: stalled vector beat with writes attempted, start poked mid-compute
    for (int i = 0; i < 16; i++) mat_in[i] = rnd16();
    load_matrix();
    for (int i = 0; i < 4; i++) v_ref[i] = rnd16();
    run_op(3, 1'b0, 1'b1, 1'b1);

    // Randomised operations
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) mat_in[i] = rnd16();
      load_matrix();
      for (int i = 0; i < 4; i++) v_ref[i] = rnd16();
`ifdef MAU_TRANSPOSE_EN
      run_op($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
`else
      run_op($urandom_range(0, 3), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
`endif
    end

`ifdef MAU_TRANSPOSE_EN
    clear_mat_in();
    mat_in[3] = 16'h0100;
    load_matrix();
    v_ref = '{16'h0200, 16'h0000, 16'h0000, 16'h0000};
    run_op(0, 1'b1, 1'b0, 1'b0);
    check("transpose_y3", 32'(y_exp[3]), 32'h0200);
    run_op(0, 1'b0, 1'b0, 1'b0);
`endif

    // Reset in the middle of COMPUTE
    for (int i = 0; i < 16; i++) mat_in[i] = rnd16();
    load_matrix();
    data_in = $urandom();
    start = 1'b1;
    tick();
    start = 1'b0;
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    repeat (3) tick();
    check("mid_compute_state", 32'(state_dbg), 32'd2);
    reset = 1'b0;
    tick();
    check("abort_data_out", data_out, 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result_ready", 32'(result_ready), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) m_ref[i] = '0;
    ba_ref = 0;
    tick();
    for (int i = 0; i < 4; i++) v_ref[i] = rnd16();
    run_op(0, 1'b0, 1'b0, 1'b0);

    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
